// File: rtl/load_store_unit_pkg.sv
// Shared size codes, FSM state encoding and datapath widths for the load/store unit.
package load_store_unit_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned SIZE_W = 3;
   localparam int unsigned BE_W   = XLEN / 8;

   localparam logic [SIZE_W-1:0] LDST_B  = 3'b000;
   localparam logic [SIZE_W-1:0] LDST_H  = 3'b001;
   localparam logic [SIZE_W-1:0] LDST_W  = 3'b010;
   localparam logic [SIZE_W-1:0] LDST_BU = 3'b100;
   localparam logic [SIZE_W-1:0] LDST_HU = 3'b101;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_BUSY = 2'd1,
      LSU_DONE = 2'd2
   } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/ready bus between the load/store unit and memory.
interface load_store_unit_if;
   import load_store_unit_pkg::*;

   logic            mem_request;
   logic            mem_write_enable;
   logic [BE_W-1:0] mem_byte_enable;
   logic [XLEN-1:0] mem_address;
   logic [XLEN-1:0] mem_write_data;
   logic [XLEN-1:0] mem_read_data;
   logic            mem_ready;

   modport master (
      output mem_request, mem_write_enable, mem_byte_enable, mem_address, mem_write_data,
      input  mem_read_data, mem_ready
   );

   modport slave (
      input  mem_request, mem_write_enable, mem_byte_enable, mem_address, mem_write_data,
      output mem_read_data, mem_ready
   );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane steering: byte enables, replicated store data, extended load data.
module lsu_lane_align
   import load_store_unit_pkg::*;
(
   input  logic [SIZE_W-1:0] size,
   input  logic [1:0]        offset,
   input  logic [XLEN-1:0]   store_data,
   input  logic [XLEN-1:0]   load_raw,
   output logic [BE_W-1:0]   byte_enable_c,
   output logic [XLEN-1:0]   store_lanes_c,
   output logic [XLEN-1:0]   load_data_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = load_raw[{offset, 3'b000} +: 8];
   assign half_sel = load_raw[{offset[1], 4'b0000} +: 16];

   always_comb begin
      byte_enable_c = '0;
      store_lanes_c = store_data;
      load_data_c   = '0;
      case (size)
         LDST_B, LDST_BU: begin
            byte_enable_c = 4'b0001 << offset;
            store_lanes_c = {4{store_data[7:0]}};
            load_data_c   = {{24{byte_sel[7] & (size == LDST_B)}}, byte_sel};
         end
         LDST_H, LDST_HU: begin
            byte_enable_c = 4'b0011 << {offset[1], 1'b0};
            store_lanes_c = {2{store_data[15:0]}};
            load_data_c   = {{16{half_sel[15] & (size == LDST_H)}}, half_sel};
         end
         LDST_W: begin
            byte_enable_c = 4'b1111;
            load_data_c   = load_raw;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns a core memory access into one bus transaction, stalling the core until done.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TIMEOUT_WIDTH  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_require,
   input  logic              core_write_enable,
   input  logic [SIZE_W-1:0] core_size,
   input  logic [XLEN-1:0]   core_address,
   input  logic [XLEN-1:0]   core_write_data,
   output logic [XLEN-1:0]   core_read_data,
   output logic              core_stall,
   output logic              misaligned,
   output logic              bus_error,
   load_store_unit_if.master mem
);

   localparam int unsigned TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

   lsu_state_e               state;
   logic [SIZE_W-1:0]        size_q;
   logic [1:0]               offset_q;
   logic [TIMEOUT_WIDTH-1:0] timeout_cnt;

   logic              fault_c;
   logic              accept_c;
   logic              timeout_c;
   logic [SIZE_W-1:0] align_size;
   logic [1:0]        align_offset;
   logic [BE_W-1:0]   align_be;
   logic [XLEN-1:0]   align_wdata;
   logic [XLEN-1:0]   align_rdata;

   // Illegal size codes, unaligned halves/words and unsigned-size stores are all rejected.
   always_comb begin
      fault_c = 1'b1;
      case (core_size)
         LDST_B:  fault_c = 1'b0;
         LDST_H:  fault_c = core_address[0];
         LDST_W:  fault_c = |core_address[1:0];
         LDST_BU: fault_c = core_write_enable;
         LDST_HU: fault_c = core_write_enable | core_address[0];
         default: fault_c = 1'b1;
      endcase
   end

   assign accept_c   = reset && (state == LSU_IDLE) && core_require && !fault_c;
   assign misaligned = reset && (state == LSU_IDLE) && core_require && fault_c;
   assign core_stall = (state == LSU_BUSY) || accept_c;
   assign timeout_c  = (TIMEOUT_CYCLES != 0) && (timeout_cnt == TIMEOUT_WIDTH'(TIMEOUT_LAST));

   // Request side steers from the live core inputs; response side from the latched request.
   assign align_size   = (state == LSU_IDLE) ? core_size : size_q;
   assign align_offset = (state == LSU_IDLE) ? core_address[1:0] : offset_q;

   lsu_lane_align u_lane_align (
      .size          (align_size),
      .offset        (align_offset),
      .store_data    (core_write_data),
      .load_raw      (mem.mem_read_data),
      .byte_enable_c (align_be),
      .store_lanes_c (align_wdata),
      .load_data_c   (align_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                <= LSU_IDLE;
         size_q               <= '0;
         offset_q             <= '0;
         timeout_cnt          <= '0;
         core_read_data       <= '0;
         bus_error            <= 1'b0;
         mem.mem_request      <= 1'b0;
         mem.mem_write_enable <= 1'b0;
         mem.mem_byte_enable  <= '0;
         mem.mem_address      <= '0;
         mem.mem_write_data   <= '0;
      end else begin
         case (state)
            LSU_IDLE: begin
               if (accept_c) begin
                  state                <= LSU_BUSY;
                  size_q               <= core_size;
                  offset_q             <= core_address[1:0];
                  timeout_cnt          <= '0;
                  mem.mem_request      <= 1'b1;
                  mem.mem_write_enable <= core_write_enable;
                  mem.mem_byte_enable  <= align_be;
                  mem.mem_address      <= {core_address[XLEN-1:2], 2'b00};
                  mem.mem_write_data   <= align_wdata;
               end
            end
            LSU_BUSY: begin
               if (mem.mem_ready) begin
                  state           <= LSU_DONE;
                  mem.mem_request <= 1'b0;
                  core_read_data  <= mem.mem_write_enable ? '0 : align_rdata;
               end else if (timeout_c) begin
                  state           <= LSU_DONE;
                  mem.mem_request <= 1'b0;
                  core_read_data  <= '0;
                  bus_error       <= 1'b1;
               end else begin
                  timeout_cnt <= timeout_cnt + 1'b1;
               end
            end
            LSU_DONE: begin
               // Result is only meaningful for the single DONE cycle.
               state          <= LSU_IDLE;
               core_read_data <= '0;
               bus_error      <= 1'b0;
            end
            default: state <= LSU_IDLE;
         endcase
      end
   end

endmodule
